// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit with split misaligned access
module load_store_unit #(
    parameter int ADDR_WIDTH       = 15,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_address,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [3:0]            mem_byteena,
    output logic [31:0]           mem_data,
    output logic                  mem_wren,
    input  logic [31:0]           mem_q
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    state_t                state;
    logic                  r_write;
    logic [2:0]            r_funct3;
    logic [1:0]            r_offset;
    logic [7:0]            r_mask;
    logic [63:0]           r_lane;
    logic [ADDR_WIDTH-1:0] r_wa;
    logic [31:0]           r_lo;

    logic [7:0]            in_mask;
    logic [7:0]            in_base;
    logic [63:0]           in_lane;
    logic                  in_illegal;
    logic                  in_misalign_err;
    logic [ADDR_WIDTH-1:0] in_wa;
    logic                  unused_addr_bits;

    assign req_ready = (state == IDLE);
    assign in_wa     = req_address[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^req_address[31:ADDR_WIDTH+2];

    always_comb begin
        in_base = 8'h0F;
        case (req_funct3[1:0])
            2'b00:   in_base = 8'h01;
            2'b01:   in_base = 8'h03;
            default: in_base = 8'h0F;
        endcase
        in_mask = in_base << req_address[1:0];
        in_lane = {32'h0, req_wdata} << {req_address[1:0], 3'b000};
        if (req_write)
            in_illegal = (req_funct3 > 3'b010);
        else
            in_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        in_misalign_err = !ALLOW_MISALIGNED && (in_mask[7:4] != 4'h0);
    end

    // Shift the two-word window down to the access offset, then extend by funct3.
    function automatic logic [31:0] extend_load(input logic [63:0] x,
                                                input logic [1:0]  o,
                                                input logic [2:0]  f3);
        logic [63:0] sh;
        sh = x >> {o, 3'b000};
        case (f3[1:0])
            2'b00:   extend_load = f3[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
            2'b01:   extend_load = f3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: extend_load = sh[31:0];
        endcase
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            r_write     <= 1'b0;
            r_funct3    <= 3'b000;
            r_offset    <= 2'b00;
            r_mask      <= 8'h00;
            r_lane      <= 64'h0;
            r_wa        <= '0;
            r_lo        <= 32'h0;
            resp_valid  <= 1'b0;
            resp_error  <= 1'b0;
            resp_rdata  <= 32'h0;
            mem_address <= '0;
            mem_byteena <= 4'h0;
            mem_data    <= 32'h0;
            mem_wren    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_write  <= req_write;
                        r_funct3 <= req_funct3;
                        r_offset <= req_address[1:0];
                        r_mask   <= in_mask;
                        r_lane   <= in_lane;
                        r_wa     <= in_wa;
                        r_lo     <= 32'h0;
                        if (in_illegal || in_misalign_err) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            state       <= ACC0;
                            mem_address <= in_wa;
                            mem_byteena <= in_mask[3:0];
                            mem_data    <= in_lane[31:0];
                            mem_wren    <= req_write;
                        end
                    end
                end
                ACC0: begin
                    if (!r_write)
                        r_lo <= mem_q;
                    if (r_mask[7:4] != 4'h0) begin
                        state       <= ACC1;
                        mem_address <= r_wa + ADDR_WIDTH'(1);
                        mem_byteena <= r_mask[7:4];
                        mem_data    <= r_lane[63:32];
                        mem_wren    <= r_write;
                    end else begin
                        state       <= DONE;
                        mem_byteena <= 4'h0;
                        mem_wren    <= 1'b0;
                        resp_valid  <= 1'b1;
                        resp_error  <= 1'b0;
                        resp_rdata  <= r_write ? 32'h0
                                     : extend_load({32'h0, mem_q}, r_offset, r_funct3);
                    end
                end
                ACC1: begin
                    // The high word comes straight from mem_q; the low word was held in r_lo.
                    state       <= DONE;
                    mem_byteena <= 4'h0;
                    mem_wren    <= 1'b0;
                    resp_valid  <= 1'b1;
                    resp_error  <= 1'b0;
                    resp_rdata  <= r_write ? 32'h0
                                 : extend_load({mem_q, r_lo}, r_offset, r_funct3);
                end
                DONE: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
